reg_access_ctrl: RTL and testbench

Command-driven initiator for the 32×32 two-read/one-write register file. It accepts write, read-pair, dump and clear commands on a valid/ready command port. It sequences the register file's R_Addr_A/R_Addr_B/W_Addr/W_Data/Write_Reg pins and returns read data on a valid/ready response port. It sits between the debug/test front-end and the register file, and owns those pins whenever the datapath is held off.

---
 rtl/reg_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - command-driven initiator sequencing a 2R/1W register file
module reg_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              rsp_last,
    output logic              busy,
    // register-file pins
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(NREG / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP,
        S_DUMP_RD,
        S_DUMP_RSP,
        S_CLEAR
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_k;
    logic [ADDR_W-1:0]  r_cmd_addr_a;
    logic               r_rsp_valid;
    logic [ADDR_W-1:0]  r_rsp_addr;
    logic [DATA_W-1:0]  r_rsp_data_a;
    logic [DATA_W-1:0]  r_rsp_data_b;
    logic               r_rsp_last;
    logic [ADDR_W-1:0]  r_raddr_a;
    logic [ADDR_W-1:0]  r_raddr_b;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_write_reg;

    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_rsp_hs;
    logic [ADDR_W-1:0]  w_k_next;

    assign w_cmd_ready = (r_state == S_IDLE) & ~reset;
    assign w_accept    = cmd_valid & w_cmd_ready;
    assign w_rsp_hs    = r_rsp_valid & rsp_ready;
    assign w_k_next    = r_k + ONE_A;

    // Main sequencer: one state register plus all registered pin/response outputs.
    // Reset abandons any command in flight, dropping a pending beat and further writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_cmd_addr_a <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_addr   <= '0;
            r_rsp_data_a <= '0;
            r_rsp_data_b <= '0;
            r_rsp_last   <= 1'b0;
            r_raddr_a    <= '0;
            r_raddr_b    <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_write_reg  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_addr_a <= cmd_addr_a;
                        case (cmd_op)
                            OP_WRITE: begin
                                r_state     <= S_WRITE;
                                r_write_reg <= 1'b1;
                                r_waddr     <= cmd_addr_a;
                                r_wdata     <= cmd_wdata;
                            end
                            OP_READ: begin
                                r_state   <= S_READ;
                                r_raddr_a <= cmd_addr_a;
                                r_raddr_b <= cmd_addr_b;
                            end
                            OP_DUMP: begin
                                r_state   <= S_DUMP_RD;
                                r_k       <= '0;
                                r_raddr_a <= '0;
                                r_raddr_b <= ONE_A;
                            end
                            OP_CLEAR: begin
                                r_state     <= S_CLEAR;
                                r_write_reg <= 1'b1;
                                r_waddr     <= '0;
                                r_wdata     <= '0;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end

                // single write pulse already driven on entry; drop it and return
                S_WRITE: begin
                    r_write_reg <= 1'b0;
                    r_state     <= S_IDLE;
                end

                // read data is combinational from the addresses set on entry
                S_READ: begin
                    r_rsp_data_a <= R_Data_A;
                    r_rsp_data_b <= R_Data_B;
                    r_rsp_addr   <= r_cmd_addr_a;
                    r_rsp_last   <= 1'b1;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end

                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                // beat k reads registers 2k and 2k+1 in one cycle
                S_DUMP_RD: begin
                    r_rsp_data_a <= R_Data_A;
                    r_rsp_data_b <= R_Data_B;
                    r_rsp_addr   <= r_k << 1;
                    r_rsp_last   <= (r_k == LAST_K);
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_DUMP_RSP;
                end

                S_DUMP_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_k       <= w_k_next;
                            r_raddr_a <= w_k_next << 1;
                            r_raddr_b <= (w_k_next << 1) | ONE_A;
                            r_state   <= S_DUMP_RD;
                        end
                    end
                end

                // sweep W_Addr upward with Write_Reg held high, one register per cycle
                S_CLEAR: begin
                    if (r_waddr == LAST_REG) begin
                        r_write_reg <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_waddr <= r_waddr + ONE_A;
                    end
                end

                default: begin
                    r_write_reg <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data_a = r_rsp_data_a;
    assign rsp_data_b = r_rsp_data_b;
    assign rsp_last   = r_rsp_last;
    assign R_Addr_A   = r_raddr_a;
    assign R_Addr_B   = r_raddr_b;
    assign W_Addr     = r_waddr;
    assign W_Data     = r_wdata;
    assign Write_Reg  = r_write_reg;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - randomized self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a;
    logic [AW-1:0] cmd_addr_b;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data_a;
    logic [DW-1:0] rsp_data_b;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] R_Addr_A;
    logic [AW-1:0] R_Addr_B;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Write_Reg;
    logic [DW-1:0] R_Data_A;
    logic [DW-1:0] R_Data_B;

    always #5 clk = ~clk;

    reg_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_last(rsp_last),
        .busy(busy),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .W_Data(W_Data),
        .Write_Reg(Write_Reg), .R_Data_A(R_Data_A), .R_Data_B(R_Data_B)
    );

    // physical register file the controller drives (not reset, like the real array)
    logic [DW-1:0] rf [NR];
    assign R_Data_A = rf[R_Addr_A];
    assign R_Data_B = rf[R_Addr_B];
    always @(posedge clk) if (Write_Reg) rf[W_Addr] <= W_Data;

    // command-level reference contents
    logic [DW-1:0] model [NR];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {cmd_ready, busy, rsp_valid, rsp_last, rsp_addr, rsp_data_a, rsp_data_b,
                    R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg}, 128'd0);
    endtask

    // present a command from a negedge, return at the negedge after acceptance
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [AW-1:0] b, input logic [DW-1:0] d);
        int n = 0;
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // collect one response beat; stalls with random ready unless rdy_hi
    task automatic get_beat(input bit rdy_hi, output logic [AW-1:0] ad,
                            output logic [DW-1:0] da, output logic [DW-1:0] db,
                            output logic la);
        int n = 0;
        bit done = 0;
        bit have = 0;
        logic [AW+2*DW:0] snap = '0;
        ad = '0; da = '0; db = '0; la = 1'b0;
        while (!done && n < 300) begin
            if (rsp_valid) begin
                if (have) check("stall_stable", {rsp_addr, rsp_data_a, rsp_data_b, rsp_last}, snap);
                snap = {rsp_addr, rsp_data_a, rsp_data_b, rsp_last};
                have = 1;
                rsp_ready = rdy_hi ? 1'b1 : 1'($urandom_range(0, 1));
                ad = rsp_addr; da = rsp_data_a; db = rsp_data_b; la = rsp_last;
                if (rsp_ready) done = 1;
            end
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            n++;
        end
        if (!done) check("beat_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send_cmd(2'b00, a, '0, d);
        check("wr_pulse", {Write_Reg, W_Addr, W_Data, cmd_ready}, {1'b1, a, d, 1'b0});
        model[a] = d;
        @(negedge clk);
        check("wr_end", {Write_Reg, cmd_ready}, 2'b01);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit rdy_hi);
        logic [AW-1:0] ad;
        logic [DW-1:0] da, db;
        logic la;
        send_cmd(2'b01, a, b, '0);
        check("rd_lat1", rsp_valid, 1'b0);
        @(negedge clk);
        check("rd_lat2", rsp_valid, 1'b1);
        get_beat(rdy_hi, ad, da, db, la);
        check("rd_beat", {ad, da, db, la}, {a, model[a], model[b], 1'b1});
        check("rd_idle", {busy, rsp_valid, cmd_ready}, 3'b001);
    endtask

    task automatic do_dump(input bit rdy_hi, input int nbeats, output int cycles);
        logic [AW-1:0] ad, ea;
        logic [DW-1:0] da, db;
        logic la;
        int t0;
        send_cmd(2'b10, '0, '0, '0);
        t0 = cyc;
        for (int k = 0; k < nbeats; k++) begin
            get_beat(rdy_hi, ad, da, db, la);
            ea = AW'(2 * k);
            check("dump_beat", {ad, da, db, la},
                  {ea, model[2*k], model[2*k+1], 1'(k == NR/2 - 1)});
        end
        cycles = cyc - t0;
    endtask

    task automatic quiet_after_reset();
        bit seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Write_Reg || rsp_valid) seen = 1;
            @(negedge clk);
        end
        check("quiet_after_reset", seen, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_used;
        logic [AW-1:0] a, b;
        logic [DW-1:0] d;
        logic [AW+2*DW:0] snap;

        for (int i = 0; i < NR; i++) model[i] = '0;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_vals");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);

        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd5, 32'h1234);
        do_write(5'd6, 32'h5678);
        do_read(5'd5, 5'd6, 1'b1);

        // hold the beat for 10 cycles
        send_cmd(2'b01, 5'd5, 5'd6, '0);
        @(negedge clk);
        snap = {rsp_addr, rsp_data_a, rsp_data_b, rsp_last};
        for (int i = 0; i < 10; i++) begin
            check("hold", {rsp_valid, rsp_addr, rsp_data_a, rsp_data_b, rsp_last}, {1'b1, snap});
            @(negedge clk);
        end
        begin
            logic [AW-1:0] ad; logic [DW-1:0] da, db; logic la;
            get_beat(1'b1, ad, da, db, la);
            check("hold_beat", {ad, da, db, la}, {5'd5, 32'h1234, 32'h5678, 1'b1});
            check("hold_idle", {busy, rsp_valid}, 2'b00);
        end

        for (int i = 0; i < NR; i++) do_write(AW'(i), DW'(i * 3));
        do_dump(1'b0, NR/2, cyc_used);
        check("dump_idle", {busy, rsp_valid, cmd_ready}, 3'b001);

        for (int i = 0; i < 30; i++) begin
            a = AW'($urandom_range(0, NR-1));
            b = AW'($urandom_range(0, NR-1));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) do_write(a, d);
            else do_read(a, b, 1'($urandom_range(0, 1)));
        end
        do_read(5'd0, 5'd31, 1'b0);

        for (int i = 0; i < NR; i++) do_write(AW'(i), $urandom | 32'h1);
        send_cmd(2'b11, '0, '0, '0);
        for (int i = 0; i < NR; i++) begin
            check("clear_cycle", {Write_Reg, W_Addr, W_Data, busy}, {1'b1, AW'(i), 32'd0, 1'b1});
            @(negedge clk);
        end
        check("clear_end", {Write_Reg, busy, cmd_ready}, 3'b001);
        for (int i = 0; i < NR; i++) model[i] = '0;
        do_dump(1'b1, NR/2, cyc_used);
        check("dump_cycles", cyc_used, 32);
        check("dump2_idle", {busy, rsp_valid}, 2'b00);

        // reset during beat 7 of a dump
        for (int i = 0; i < NR; i++) do_write(AW'(i), $urandom);
        do_dump(1'b0, 7, cyc_used);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
            check("beat7_valid", {rsp_valid, rsp_addr}, {1'b1, 5'd14});
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_mid_dump");
        reset = 1'b0;
        quiet_after_reset();
        do_read(5'd14, 5'd15, 1'b1);

        // reset during cycle 10 of a clear: registers 0..9 are already zeroed
        for (int i = 0; i < 12; i++) do_write(AW'(i), $urandom | 32'h1);
        send_cmd(2'b11, '0, '0, '0);
        repeat (9) @(negedge clk);
        check("clear_cycle10", {Write_Reg, W_Addr}, {1'b1, 5'd9});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_mid_clear");
        for (int i = 0; i < 10; i++) model[i] = '0;
        reset = 1'b0;
        quiet_after_reset();
        do_read(5'd9, 5'd10, 1'b1);
        do_read(5'd0, 5'd11, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
